// File: rtl/core_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : core_switch_ctrl
//  Brief    : Dual-CPU redundancy controller. Watches a heartbeat from each
//             core, fails over to the surviving core on heartbeat loss,
//             honours manual switch requests and holds off re-switching for
//             a fixed window after every switch. ctr_io selects the pin owner
//             (0 = CPU A, 1 = CPU B).
//  Revision : 1.0 - initial release
// ============================================================================
module core_switch_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hb_a,
    input  logic       hb_b,
    input  logic       force_a,
    input  logic       force_b,
    output logic       ctr_io,
    output logic       a_alive,
    output logic       b_alive,
    output logic       fail_both,
    output logic       switch_evt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_ACT_A  = 2'b00,
        ST_ACT_B  = 2'b01,
        ST_HOLD_A = 2'b10,
        ST_HOLD_B = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    // Lane 0 is CPU A, lane 1 is CPU B.
    logic [1:0] w_hb;
    logic [1:0] w_alive;

    assign w_hb = {hb_b, hb_a};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_lane
            // Bits [1:0] form the synchroniser; bit 2 is the previous synced
            // value used for the any-transition edge detector.
            logic [2:0]       r_sync_q;
            logic [2:0]       w_sync_d;
            logic [CNT_W-1:0] r_wd_q;
            logic [CNT_W-1:0] w_wd_d;
            logic             r_alive_q;
            logic             w_alive_d;
            logic             w_hb_edge;

            assign w_hb_edge = r_sync_q[1] ^ r_sync_q[2];

            // Watchdog: restart on a heartbeat edge, otherwise count up and
            // stick at the timeout value so it never wraps back to "alive".
            always_comb begin
                w_sync_d = {r_sync_q[1:0], w_hb[i]};
                w_wd_d   = r_wd_q;
                if (w_hb_edge) begin
                    w_wd_d = '0;
                end else if (r_wd_q < c_timeout) begin
                    w_wd_d = r_wd_q + c_one;
                end
                w_alive_d = (w_wd_d < c_timeout);
            end

            // Heartbeat lane registers; alive tracks the counter it is
            // registered alongside.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync_q  <= '0;
                    r_wd_q    <= '0;
                    r_alive_q <= 1'b1;
                end else begin
                    r_sync_q  <= w_sync_d;
                    r_wd_q    <= w_wd_d;
                    r_alive_q <= w_alive_d;
                end
            end

            assign w_alive[i] = r_alive_q;
        end
    endgenerate

    state_t           r_state_q;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_hold_q;
    logic [CNT_W-1:0] w_hold_d;
    logic             r_ctr_io_q;
    logic             w_ctr_io_d;
    logic             r_switch_evt_q;
    logic             w_switch_evt_d;
    logic             r_fail_both_q;
    logic             w_fail_both_d;
    logic             w_to_a;
    logic             w_to_b;

    // Auto failover and manual request collapse to the same move; a request
    // toward a dead core or with both forces high never qualifies.
    assign w_to_b = (!w_alive[0] && w_alive[1]) || (force_b && !force_a && w_alive[1]);
    assign w_to_a = (!w_alive[1] && w_alive[0]) || (force_a && !force_b && w_alive[0]);

    // Next-state logic: switch only from ACT states; HOLD just runs out its
    // window and ignores every request and alive change.
    always_comb begin
        w_state_d      = r_state_q;
        w_hold_d       = r_hold_q;
        w_switch_evt_d = 1'b0;
        w_fail_both_d  = !w_alive[0] && !w_alive[1];
        case (r_state_q)
            ST_ACT_A: begin
                if (w_to_b) begin
                    w_state_d      = ST_HOLD_B;
                    w_hold_d       = '0;
                    w_switch_evt_d = 1'b1;
                end
            end
            ST_ACT_B: begin
                if (w_to_a) begin
                    w_state_d      = ST_HOLD_A;
                    w_hold_d       = '0;
                    w_switch_evt_d = 1'b1;
                end
            end
            ST_HOLD_A: begin
                if (r_hold_q == c_hold_last) begin
                    w_state_d = ST_ACT_A;
                end else begin
                    w_hold_d = r_hold_q + c_one;
                end
            end
            ST_HOLD_B: begin
                if (r_hold_q == c_hold_last) begin
                    w_state_d = ST_ACT_B;
                end else begin
                    w_hold_d = r_hold_q + c_one;
                end
            end
        endcase
        w_ctr_io_d = (w_state_d == ST_ACT_B) || (w_state_d == ST_HOLD_B);
    end

    // Controller registers; ctr_io and switch_evt change in the same clock
    // as the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_ACT_A;
            r_hold_q       <= '0;
            r_ctr_io_q     <= 1'b0;
            r_switch_evt_q <= 1'b0;
            r_fail_both_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_hold_q       <= w_hold_d;
            r_ctr_io_q     <= w_ctr_io_d;
            r_switch_evt_q <= w_switch_evt_d;
            r_fail_both_q  <= w_fail_both_d;
        end
    end

    assign ctr_io     = r_ctr_io_q;
    assign a_alive    = w_alive[0];
    assign b_alive    = w_alive[1];
    assign fail_both  = r_fail_both_q;
    assign switch_evt = r_switch_evt_q;
    assign state      = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_core_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_switch_ctrl
//  Brief    : Scoreboard bench for core_switch_ctrl. The stimulus process
//             drives heartbeats, forces and resets, predicts every clock's
//             outputs from a timestamp-based reference model and queues
//             them; a monitor process pops and compares each clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_switch_ctrl;

    localparam int c_to   = 100;
    localparam int c_hold = 16;
    localparam int c_len  = 16384;

    logic       clk;
    logic       rst;
    logic       hb_a;
    logic       hb_b;
    logic       force_a;
    logic       force_b;
    logic       ctr_io;
    logic       a_alive;
    logic       b_alive;
    logic       fail_both;
    logic       switch_evt;
    logic [1:0] state;

    core_switch_ctrl #(
        .TIMEOUT_CYCLES (c_to),
        .HOLDOFF_CYCLES (c_hold),
        .CNT_W          (16)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .hb_a       (hb_a),
        .hb_b       (hb_b),
        .force_a    (force_a),
        .force_b    (force_b),
        .ctr_io     (ctr_io),
        .a_alive    (a_alive),
        .b_alive    (b_alive),
        .fail_both  (fail_both),
        .switch_evt (switch_evt),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output vector: {state[1:0], ctr_io, a_alive, b_alive, fail_both, switch_evt}
    logic [6:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    // Reference model state. Edges are numbered; a pin value "seen" at edge k
    // is what the core's input flop holds after k (reset forces it to 0).
    // A change first seen at edge k refreshes that core's watchdog at k+2.
    bit seen_a [0:c_len-1];
    bit seen_b [0:c_len-1];
    int e_now;
    int last_ref_a, last_ref_b;
    bit m_alive_a, m_alive_b, m_fail;
    bit m_owner_b, m_holding, m_evt;
    int hold_at;

    // Stimulus-side pin generators: per_x = 0 means the heartbeat is stopped.
    bit pin_a, pin_b;
    int per_a, per_b, cnt_a, cnt_b;

    task automatic model_edge(input bit pa, input bit pb, input bit fa, input bit fb, input bit r);
        bit pal, pbl, want;
        pal = m_alive_a;
        pbl = m_alive_b;
        if (r) begin
            seen_a[e_now] = 1'b0; seen_a[e_now-1] = 1'b0; seen_a[e_now-2] = 1'b0;
            seen_b[e_now] = 1'b0; seen_b[e_now-1] = 1'b0; seen_b[e_now-2] = 1'b0;
            last_ref_a = e_now;
            last_ref_b = e_now;
            m_alive_a  = 1'b1;
            m_alive_b  = 1'b1;
            m_fail     = 1'b0;
            m_owner_b  = 1'b0;
            m_holding  = 1'b0;
            m_evt      = 1'b0;
        end else begin
            seen_a[e_now] = pa;
            seen_b[e_now] = pb;
            if (seen_a[e_now-2] != seen_a[e_now-3]) last_ref_a = e_now;
            if (seen_b[e_now-2] != seen_b[e_now-3]) last_ref_b = e_now;
            m_alive_a = (e_now - last_ref_a) < c_to;
            m_alive_b = (e_now - last_ref_b) < c_to;
            m_fail    = !pal && !pbl;
            m_evt     = 1'b0;
            if (m_holding) begin
                if (e_now == hold_at + c_hold) m_holding = 1'b0;
            end else begin
                if (!m_owner_b) want = (!pal && pbl) || (fb && !fa && pbl);
                else            want = (!pbl && pal) || (fa && !fb && pal);
                if (want) begin
                    m_owner_b = !m_owner_b;
                    m_holding = 1'b1;
                    hold_at   = e_now;
                    m_evt     = 1'b1;
                end
            end
        end
        exp_q.push_back({m_holding, m_owner_b, m_owner_b, m_alive_a, m_alive_b, m_fail, m_evt});
    endtask

    // One clock of stimulus: advance pin generators, drive, predict, wait.
    task automatic step(input bit fa, input bit fb, input bit r);
        if (per_a != 0) begin
            cnt_a++;
            if (cnt_a >= per_a) begin cnt_a = 0; pin_a = ~pin_a; end
        end
        if (per_b != 0) begin
            cnt_b++;
            if (cnt_b >= per_b) begin cnt_b = 0; pin_b = ~pin_b; end
        end
        hb_a    = pin_a;
        hb_b    = pin_b;
        force_a = fa;
        force_b = fb;
        rst     = r;
        e_now++;
        model_edge(pin_a, pin_b, fa, fb, r);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare the DUT's outputs for each edge against the queue.
    initial begin
        logic [6:0] got;
        logic [6:0] exp;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {state, ctr_io, a_alive, b_alive, fail_both, switch_evt};
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL outputs t=%0t got st=%b io=%b aa=%b ba=%b fb=%b ev=%b exp st=%b io=%b aa=%b ba=%b fb=%b ev=%b",
                             $time, got[6:5], got[4], got[3], got[2], got[1], got[0],
                             exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; hb_a = 1'b0; hb_b = 1'b0; force_a = 1'b0; force_b = 1'b0;
        e_now = 4; last_ref_a = 0; last_ref_b = 0; hold_at = 0;
        m_alive_a = 1'b1; m_alive_b = 1'b1; m_fail = 1'b0;
        m_owner_b = 1'b0; m_holding = 1'b0; m_evt = 1'b0;
        pin_a = 1'b0; pin_b = 1'b0; cnt_a = 0; cnt_b = 0;
        per_a = 20; per_b = 20;

        // Reset, then steady heartbeats on both cores.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        run(1000);

        // Lose CPU A: auto failover to B, then hold window.
        per_a = 0;
        run(150);

        // A returns; manual force to A, force_b inside HOLD_A is ignored.
        per_a = 20;
        run(30);
        step(1'b1, 1'b0, 1'b0);
        run(4);
        step(1'b0, 1'b1, 1'b0);
        run(30);

        // Simultaneous forces ignored; force toward dead B ignored.
        step(1'b1, 1'b1, 1'b0);
        run(5);
        per_b = 0;
        run(120);
        step(1'b0, 1'b1, 1'b0);
        run(20);

        // Both dead then B recovers alone.
        per_b = 20;
        run(30);
        per_a = 0; per_b = 0;
        run(150);
        per_b = 20;
        run(40);

        // Reset in the middle of HOLD_B.
        per_a = 20;
        run(30);
        step(1'b1, 1'b0, 1'b0);
        run(20);
        step(1'b0, 1'b1, 1'b0);
        run(5);
        step(1'b0, 1'b0, 1'b1);
        run(20);

        // Randomised traffic: heartbeat periods (incl. stopped and slower than
        // the timeout), random force pulses and occasional resets.
        for (int blk = 0; blk < 20; blk++) begin
            per_a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 130));
            per_b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 130));
            for (int i = 0; i < 150; i++) begin
                bit fa, fb, r;
                fa = 1'b0; fb = 1'b0;
                if ($urandom_range(0, 15) == 0) begin
                    fa = 1'($urandom_range(0, 1));
                    fb = 1'($urandom_range(0, 1));
                end
                r = ($urandom_range(0, 599) == 0);
                step(fa, fb, r);
            end
        end

        #10;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
